// File: rtl/water_level_matrix_scanner.sv
// rtl/water_level_matrix_scanner.sv - column-multiplexed water-level bar display with animation and error blink
module water_level_matrix_scanner #(
    parameter int ROWS         = 7,
    parameter int COLS         = 5,
    parameter int LEVEL_W      = 2,
    parameter int SCAN_DIV     = 1000,
    parameter int ANIM_FRAMES  = 8,
    parameter int BLINK_FRAMES = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               error,
    output logic [COLS-1:0]    col_sel_n,
    output logic [ROWS-1:0]    row_n,
    output logic               frame_tick,
    output logic               animating
);
    localparam int LEVELS  = 2 ** LEVEL_W;
    localparam int STEP    = (ROWS - 1) / (LEVELS - 1);
    localparam int DIV_W   = $clog2(SCAN_DIV + 1);
    localparam int COL_W   = $clog2(COLS);
    localparam int ANIM_W  = $clog2(ANIM_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    if (COLS < 3 || SCAN_DIV < 1 || ANIM_FRAMES < 1 || BLINK_FRAMES < 1 || STEP < 1) begin : g_bad_params
        $error("water_level_matrix_scanner: illegal parameter combination");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LEVEL_W-1:0] disp_q, disp_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic               err_q, err_d;
    logic               blink_on_q, blink_on_d;
    logic [ANIM_W-1:0]  anim_q, anim_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [COLS-1:0]    col_sel_n_q, col_sel_n_d;
    logic [ROWS-1:0]    row_n_q, row_n_d;
    logic               frame_tick_q;
    logic               animating_q;
    logic               div_wrap;
    logic               frame_end;
    logic [ROWS-1:0]    bar;
    int                 lit_rows;

    // Scan counters and frame-boundary updates of latched inputs, animation and blink.
    always_comb begin
        div_wrap   = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end  = div_wrap && (col_q == COL_W'(COLS - 1));
        div_d      = div_wrap ? '0 : div_q + 1'b1;
        col_d      = col_q;
        disp_d     = disp_q;
        target_d   = target_q;
        err_d      = err_q;
        blink_on_d = blink_on_q;
        anim_d     = anim_q;
        blink_d    = blink_q;
        if (div_wrap) begin
            col_d = frame_end ? '0 : col_q + 1'b1;
        end
        if (frame_end) begin
            target_d = level;
            err_d    = error;
            // The walk heads for the freshly latched target so a redirect takes effect at once.
            if (anim_q == ANIM_W'(ANIM_FRAMES - 1)) begin
                anim_d = '0;
                if (disp_q < level) begin
                    disp_d = disp_q + 1'b1;
                end else if (disp_q > level) begin
                    disp_d = disp_q - 1'b1;
                end
            end else begin
                anim_d = anim_q + 1'b1;
            end
            // Blink phase counts only frames already shown in error, so the first dark phase is a full one.
            if (err_q) begin
                if (blink_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_d    = '0;
                    blink_on_d = ~blink_on_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end else begin
                blink_d    = '0;
                blink_on_d = 1'b1;
            end
        end
    end

    // Image for the column about to be selected, built from next-state values so it changes with col.
    always_comb begin
        lit_rows = 1 + int'(disp_d) * STEP;
        if (lit_rows > ROWS) begin
            lit_rows = ROWS;
        end
        bar = '1;
        for (int r = 0; r < ROWS; r++) begin
            bar[r] = !(r < lit_rows);
        end
        col_sel_n_d = ~(COLS'(1) << col_d);
        if (err_d) begin
            row_n_d = blink_on_d ? '1 : '0;
        end else if (col_d == '0 || col_d == COL_W'(COLS - 1)) begin
            row_n_d = '0;
        end else begin
            row_n_d = bar;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            col_q        <= '0;
            disp_q       <= '0;
            target_q     <= '0;
            err_q        <= 1'b0;
            blink_on_q   <= 1'b1;
            anim_q       <= '0;
            blink_q      <= '0;
            col_sel_n_q  <= '1;
            row_n_q      <= '1;
            frame_tick_q <= 1'b0;
            animating_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            col_q        <= col_d;
            disp_q       <= disp_d;
            target_q     <= target_d;
            err_q        <= err_d;
            blink_on_q   <= blink_on_d;
            anim_q       <= anim_d;
            blink_q      <= blink_d;
            col_sel_n_q  <= col_sel_n_d;
            row_n_q      <= row_n_d;
            frame_tick_q <= frame_end;
            animating_q  <= (disp_d != target_d);
        end
    end

    assign col_sel_n  = col_sel_n_q;
    assign row_n      = row_n_q;
    assign frame_tick = frame_tick_q;
    assign animating  = animating_q;
endmodule

// File: tb/tb_water_level_matrix_scanner.sv
// tb/tb_water_level_matrix_scanner.sv - directed table-driven bench for water_level_matrix_scanner
module tb_water_level_matrix_scanner;
    localparam int ROWS = 7, COLS = 5, LEVEL_W = 2, SCAN_DIV = 4, ANIM_FRAMES = 2, BLINK_FRAMES = 3;

    typedef struct {
        logic [1:0] lvl;
        logic       err;
        logic [6:0] inner;
        logic [6:0] wall;
        logic       anim;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [LEVEL_W-1:0] level = '0;
    logic               error = 1'b0;
    logic [COLS-1:0]    col_sel_n;
    logic [ROWS-1:0]    row_n;
    logic               frame_tick;
    logic               animating;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    water_level_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .LEVEL_W(LEVEL_W), .SCAN_DIV(SCAN_DIV),
        .ANIM_FRAMES(ANIM_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .level(level), .error(error),
        .col_sel_n(col_sel_n), .row_n(row_n), .frame_tick(frame_tick), .animating(animating)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_tick_timeout: got none expected pulse within 200 cycles");
        end
    endtask

    task automatic sample_frame(input string name, input logic [6:0] inner, input logic [6:0] wall,
                                input logic anim);
        bit ok;
        wait_tick(ok);
        if (ok) begin
            check({name, "_col0_sel"}, 32'(col_sel_n), 32'(5'b11110));
            check({name, "_wall"}, 32'(row_n), 32'(wall));
            check({name, "_animating"}, 32'(animating), 32'(anim));
            repeat (SCAN_DIV) @(negedge clk);
            check({name, "_col1_sel"}, 32'(col_sel_n), 32'(5'b11101));
            check({name, "_inner"}, 32'(row_n), 32'(inner));
        end
    endtask

    initial begin
        bit ok;
        int cnt;

        // B1..B26: one row per frame boundary; inputs set right after the previous tick.
        tbl.push_back('{2'd0, 1'b0, 7'b1111110, 7'b0000000, 1'b0});
        tbl.push_back('{2'd3, 1'b0, 7'b1111000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 7'b1111000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 7'b1100000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 7'b1100000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 7'b0000000, 7'b0000000, 1'b0});
        tbl.push_back('{2'd0, 1'b0, 7'b0000000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd0, 1'b0, 7'b1100000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 7'b1100000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 7'b0000000, 7'b0000000, 1'b0});
        tbl.push_back('{2'd1, 1'b0, 7'b0000000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd1, 1'b0, 7'b1100000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd0, 1'b0, 7'b1100000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd0, 1'b0, 7'b1111000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd0, 1'b0, 7'b1111000, 7'b0000000, 1'b1});
        tbl.push_back('{2'd0, 1'b0, 7'b1111110, 7'b0000000, 1'b0});
        tbl.push_back('{2'd0, 1'b0, 7'b1111110, 7'b0000000, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b1111111, 7'b1111111, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b1111111, 7'b1111111, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b1111111, 7'b1111111, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b0000000, 7'b0000000, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b0000000, 7'b0000000, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b0000000, 7'b0000000, 1'b0});
        tbl.push_back('{2'd0, 1'b1, 7'b1111111, 7'b1111111, 1'b0});
        tbl.push_back('{2'd0, 1'b0, 7'b1111110, 7'b0000000, 1'b0});
        tbl.push_back('{2'd3, 1'b1, 7'b1111111, 7'b1111111, 1'b1});

        repeat (3) @(negedge clk);
        check("rst_col_sel", 32'(col_sel_n), 32'(5'b11111));
        check("rst_row", 32'(row_n), 32'(7'b1111111));
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_anim", 32'(animating), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            level = tbl[i].lvl;
            error = tbl[i].err;
            sample_frame($sformatf("vec%0d", i + 1), tbl[i].inner, tbl[i].wall, tbl[i].anim);
        end

        // Reset mid-frame at col 2, div_cnt 1.
        wait_tick(ok);
        repeat (9) @(negedge clk);
        check("pre_rst_col2", 32'(col_sel_n), 32'(5'b11011));
        reset = 1'b1;
        level = '0;
        error = 1'b0;
        @(negedge clk);
        check("midrst_col_sel", 32'(col_sel_n), 32'(5'b11111));
        check("midrst_row", 32'(row_n), 32'(7'b1111111));
        check("midrst_tick", 32'(frame_tick), 32'd0);
        check("midrst_anim", 32'(animating), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_col0", 32'(col_sel_n), 32'(5'b11110));
        check("post_rst_wall", 32'(row_n), 32'(7'b0000000));
        cnt = 1;
        while (!frame_tick && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("first_tick_latency", 32'(cnt), 32'd20);

        // One full frame: each column for SCAN_DIV cycles, one tick per 20 cycles.
        for (int k = 0; k < 20; k++) begin
            check($sformatf("sweep_sel%0d", k), 32'(col_sel_n), 32'(~(5'b00001 << (k / SCAN_DIV)) & 5'b11111));
            check($sformatf("sweep_tick%0d", k), 32'(frame_tick), 32'(k == 0));
            if (k == 4) begin
                check("sweep_inner_disp0", 32'(row_n), 32'(7'b1111110));
            end
            @(negedge clk);
        end
        check("sweep_period_tick", 32'(frame_tick), 32'd1);

        // Level 1 settles, then a brief 2 inside each frame must never latch.
        level = 2'd1;
        sample_frame("lvl1_a", 7'b1111110, 7'b0000000, 1'b1);
        sample_frame("lvl1_b", 7'b1111000, 7'b0000000, 1'b0);
        for (int f = 0; f < 3; f++) begin
            repeat (3) @(negedge clk);
            level = 2'd2;
            repeat (3) @(negedge clk);
            level = 2'd1;
            sample_frame($sformatf("glitch%0d", f), 7'b1111000, 7'b0000000, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
